// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register-file write-back
//               arbiter and scoreboard.
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;

   typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Write-back requests, issue/flush controls, scoreboard and
//               register-file write port of the write-back arbiter.
// Revision    : 1.0
// ============================================================================
interface regfile_wb_arbiter_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);
   logic                   alu_valid;
   logic [ADDR_W-1:0]      alu_addr;
   logic [XLEN-1:0]        alu_data;
   logic                   alu_ready;
   logic                   lsu_valid;
   logic [ADDR_W-1:0]      lsu_addr;
   logic [XLEN-1:0]        lsu_data;
   logic                   lsu_ready;
   logic                   issue_en;
   logic [ADDR_W-1:0]      issue_addr;
   logic                   flush;
   logic [2**ADDR_W-1:0]   busy;
   logic                   rf_write_en;
   logic [ADDR_W-1:0]      rf_write_addr;
   logic [XLEN-1:0]        rf_write_data;

   modport master (
      output alu_valid, alu_addr, alu_data,
      output lsu_valid, lsu_addr, lsu_data,
      output issue_en, issue_addr, flush,
      input  alu_ready, lsu_ready, busy,
      input  rf_write_en, rf_write_addr, rf_write_data
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  lsu_valid, lsu_addr, lsu_data,
      input  issue_en, issue_addr, flush,
      output alu_ready, lsu_ready, busy,
      output rf_write_en, rf_write_addr, rf_write_data
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter; the requester not granted last
//               wins a tie. The pointer moves only when a grant is taken.
// Revision    : 1.0
// ============================================================================
module rr_arbiter2
   import regfile_pkg::*;
(
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic i_req_alu,
   input  wire logic i_req_lsu,
   output logic      o_gnt_alu,
   output logic      o_gnt_lsu
);

   wb_src_e r_last;

   // A grant is only ever given to a valid requester, so grant == accept.
   always_comb begin
      o_gnt_alu = i_req_alu & (~i_req_lsu | (r_last == WB_LSU));
      o_gnt_lsu = i_req_lsu & (~i_req_alu | (r_last == WB_ALU));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= WB_LSU;
      end else if (o_gnt_alu) begin
         r_last <= WB_ALU;
      end else if (o_gnt_lsu) begin
         r_last <= WB_LSU;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between ALU and LSU and
//               keeps a per-register busy scoreboard for RAW hazard stalls.
// Revision    : 1.0
// ============================================================================
module regfile_wb_arbiter #(
   parameter int XLEN   = regfile_pkg::XLEN,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input wire logic             clk,
   input wire logic             reset_n,
   regfile_wb_arbiter_if.slave  bus
);

   localparam int c_NUM_REGS = 2**ADDR_W;

   logic                  w_gnt_alu;
   logic                  w_gnt_lsu;
   logic                  w_acc;
   logic [ADDR_W-1:0]     w_addr;
   logic [XLEN-1:0]       w_data;
   logic [c_NUM_REGS-1:0] w_set;
   logic [c_NUM_REGS-1:0] w_clr;
   logic [c_NUM_REGS-1:0] w_busy_nxt;

   logic                  r_we;
   logic [ADDR_W-1:0]     r_waddr;
   logic [XLEN-1:0]       r_wdata;
   logic [c_NUM_REGS-1:0] r_busy;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req_alu (bus.alu_valid),
      .i_req_lsu (bus.lsu_valid),
      .o_gnt_alu (w_gnt_alu),
      .o_gnt_lsu (w_gnt_lsu)
   );

   assign bus.alu_ready = w_gnt_alu;
   assign bus.lsu_ready = w_gnt_lsu;

   always_comb begin
      w_acc  = w_gnt_alu | w_gnt_lsu;
      w_addr = w_gnt_alu ? bus.alu_addr : bus.lsu_addr;
      w_data = w_gnt_alu ? bus.alu_data : bus.lsu_data;
   end

   // x0 is never tracked, so its set/clear strobes are tied off.
   assign w_set[0] = 1'b0;
   assign w_clr[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < c_NUM_REGS; gi++) begin : g_busy_bit
         assign w_set[gi] = bus.issue_en && (bus.issue_addr == ADDR_W'(gi));
         assign w_clr[gi] = w_acc && (w_addr == ADDR_W'(gi));
      end
   endgenerate

   // Set after clear: a newly issued producer supersedes the retiring one.
   always_comb begin
      w_busy_nxt = (r_busy & ~w_clr) | w_set;
      if (bus.flush) begin
         w_busy_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_acc && (w_addr != '0);
         if (w_acc) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
         end
      end
   end

   assign bus.busy          = r_busy;
   assign bus.rf_write_en   = r_we;
   assign bus.rf_write_addr = r_waddr;
   assign bus.rf_write_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed and randomized bench for regfile_wb_arbiter with a
//               behavioural model of arbitration, write port and scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_pass;

   regfile_wb_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   regfile_wb_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: which source was granted last, expected write port, busy set.
   bit                  m_last_lsu;
   bit                  m_we;
   logic [ADDR_W-1:0]   m_waddr;
   logic [XLEN-1:0]     m_wdata;
   bit [NUM_REGS-1:0]   m_busy;
   bit                  m_acc_alu;
   bit                  m_acc_lsu;

   function automatic bit exp_alu_ready();
      if (!bus.alu_valid) return 1'b0;
      if (!bus.lsu_valid) return 1'b1;
      return m_last_lsu;
   endfunction

   function automatic bit exp_lsu_ready();
      if (!bus.lsu_valid) return 1'b0;
      if (!bus.alu_valid) return 1'b1;
      return !m_last_lsu;
   endfunction

   task automatic model_reset();
      m_last_lsu = 1'b1;
      m_we       = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      m_busy     = '0;
      m_acc_alu  = 1'b0;
      m_acc_lsu  = 1'b0;
   endtask

   task automatic model_edge();
      bit                a;
      bit                l;
      logic [ADDR_W-1:0] wa;
      logic [XLEN-1:0]   wd;
      a  = exp_alu_ready();
      l  = exp_lsu_ready();
      wa = a ? bus.alu_addr : bus.lsu_addr;
      wd = a ? bus.alu_data : bus.lsu_data;
      if (a) m_last_lsu = 1'b0;
      if (l) m_last_lsu = 1'b1;
      m_we = (a || l) && (wa != 0);
      if (a || l) begin
         m_waddr = wa;
         m_wdata = wd;
      end
      if (bus.flush) begin
         m_busy = '0;
      end else begin
         if (a || l) m_busy[wa] = 1'b0;
         if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
      end
      m_acc_alu = a;
      m_acc_lsu = l;
   endtask

   // Advance one clock; inputs are stable here, so the model sees what the DUT sees.
   task automatic tick();
      if (reset_n) model_edge();
      else         model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid  = 1'b0;
      bus.lsu_valid  = 1'b0;
      bus.issue_en   = 1'b0;
      bus.issue_addr = '0;
      bus.flush      = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      idle_inputs();
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h1111_0001;
      bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd2; bus.lsu_data = 32'h2222_0002;
      repeat (3) tick();
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data} !== {1'b0, 5'd0, 32'd0})
         $display("FAIL reset_wport: got en=%b addr=%0d data=%h want 0/0/0",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 32'd0) $display("FAIL reset_busy: got %h want 0", bus.busy);
      else n_pass++;
      reset_n = 1'b1;
      #1;
      n_checks++;
      if ({bus.alu_ready, bus.lsu_ready} !== 2'b10)
         $display("FAIL reset_first_grant: got alu/lsu ready=%b%b want 10", bus.alu_ready, bus.lsu_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, 5'd1, 32'h1111_0001})
         $display("FAIL reset_first_write: got en=%b addr=%0d data=%h want 1/1/11110001",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_single();
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({bus.alu_ready, bus.lsu_ready} !== 2'b10)
         $display("FAIL single_ready: got alu/lsu ready=%b%b want 10", bus.alu_ready, bus.lsu_ready);
      else n_pass++;
      tick();
      bus.alu_valid = 1'b0;
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
         $display("FAIL single_write: got en=%b addr=%0d data=%h want 1/5/deadbeef",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
      else n_pass++;
      tick();
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
         $display("FAIL single_hold: got en=%b addr=%0d data=%h want 0/5/deadbeef",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
      else n_pass++;
   endtask

   task automatic test_contention();
      // Asynchronous reset between edges returns the pointer to LSU.
      #2 reset_n = 1'b0;
      model_reset();
      #1 reset_n = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA0A0_0001;
      bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd2; bus.lsu_data = 32'hB0B0_0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if ({bus.alu_ready, bus.lsu_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL contention_grant%0d: got alu/lsu ready=%b%b want %b", i,
                     bus.alu_ready, bus.lsu_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
         else n_pass++;
         tick();
         n_checks++;
         if (bus.rf_write_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2))
            $display("FAIL contention_addr%0d: got %0d want %0d", i, bus.rf_write_addr,
                     (i % 2 == 0) ? 1 : 2);
         else n_pass++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_scoreboard();
      bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
      tick();
      bus.issue_en = 1'b0;
      n_checks++;
      if (bus.busy[7] !== 1'b1) $display("FAIL sb_set7: got %b want 1", bus.busy[7]);
      else n_pass++;
      bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd7; bus.lsu_data = 32'h0000_0777;
      tick();
      bus.lsu_valid = 1'b0;
      n_checks++;
      if (bus.busy[7] !== 1'b0) $display("FAIL sb_clear7: got %b want 0", bus.busy[7]);
      else n_pass++;
      bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
      tick();
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h0000_0999;
      tick();
      n_checks++;
      if (bus.busy[9] !== 1'b1) $display("FAIL sb_set_wins9: got %b want 1", bus.busy[9]);
      else n_pass++;
      bus.issue_addr = 5'd10;
      tick();
      idle_inputs();
      n_checks++;
      if ({bus.busy[10], bus.busy[9]} !== 2'b10)
         $display("FAIL sb_diff_addr: got busy10/9=%b%b want 10", bus.busy[10], bus.busy[9]);
      else n_pass++;
      tick();
   endtask

   task automatic test_x0();
      bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'h1234_5678;
      #1;
      n_checks++;
      if (bus.alu_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", bus.alu_ready);
      else n_pass++;
      tick();
      idle_inputs();
      n_checks++;
      if ({bus.rf_write_en, bus.busy[0]} !== 2'b00)
         $display("FAIL x0_no_write: got en=%b busy0=%b want 0/0", bus.rf_write_en, bus.busy[0]);
      else n_pass++;
   endtask

   task automatic test_flush();
      bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
      tick();
      bus.issue_addr = 5'd4;
      tick();
      n_checks++;
      if (bus.busy !== m_busy || bus.busy[4:3] !== 2'b11)
         $display("FAIL flush_pre_busy: got %h want %h", bus.busy, m_busy);
      else n_pass++;
      bus.issue_addr = 5'd5;
      bus.flush = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd6; bus.alu_data = 32'h6666_6666;
      tick();
      idle_inputs();
      n_checks++;
      if (bus.busy !== 32'd0) $display("FAIL flush_busy: got %h want 0", bus.busy);
      else n_pass++;
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data} !== {1'b1, 5'd6, 32'h6666_6666})
         $display("FAIL flush_write: got en=%b addr=%0d data=%h want 1/6/66666666",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd12; bus.lsu_data = 32'hC0FF_EE00;
      bus.issue_en = 1'b1; bus.issue_addr = 5'd13;
      tick();
      idle_inputs();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data, bus.busy} !== {1'b0, 5'd0, 32'd0, 32'd0})
         $display("FAIL async_reset: got en=%b addr=%0d data=%h busy=%h want all 0",
                  bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data, bus.busy);
      else n_pass++;
      #1 reset_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         // Requests hold until accepted, then may be replaced.
         if (!bus.alu_valid || m_acc_alu) begin
            bus.alu_valid = ($urandom_range(0, 2) != 0);
            bus.alu_addr  = ADDR_W'($urandom_range(0, 31));
            bus.alu_data  = $urandom;
         end
         if (!bus.lsu_valid || m_acc_lsu) begin
            bus.lsu_valid = ($urandom_range(0, 2) != 0);
            bus.lsu_addr  = ADDR_W'($urandom_range(0, 31));
            bus.lsu_data  = $urandom;
         end
         bus.issue_en   = ($urandom_range(0, 1) == 1);
         bus.issue_addr = ADDR_W'($urandom_range(0, 31));
         bus.flush      = ($urandom_range(0, 15) == 0);
         #1;
         n_checks++;
         if ({bus.alu_ready, bus.lsu_ready} !== {exp_alu_ready(), exp_lsu_ready()})
            $display("FAIL rand_ready%0d: got alu/lsu ready=%b%b want %b%b", i,
                     bus.alu_ready, bus.lsu_ready, exp_alu_ready(), exp_lsu_ready());
         else n_pass++;
         tick();
         n_checks++;
         if (bus.rf_write_en !== m_we || bus.busy !== m_busy ||
             (m_we && {bus.rf_write_addr, bus.rf_write_data} !== {m_waddr, m_wdata}))
            $display("FAIL rand_state%0d: got en=%b addr=%0d data=%h busy=%h want en=%b addr=%0d data=%h busy=%h",
                     i, bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data, bus.busy,
                     m_we, m_waddr, m_wdata, m_busy);
         else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      bus.alu_addr = '0; bus.alu_data = '0;
      bus.lsu_addr = '0; bus.lsu_data = '0;
      idle_inputs();
      model_reset();
      #1;
      test_reset();
      test_single();
      test_contention();
      test_scoreboard();
      test_x0();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
